// File: rtl/esn_led_pkg.sv
// Shared definitions for the LED output PIO: register word addresses and
// prescaler width.
package esn_led_pkg;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_SET    = 3'd1;
    localparam logic [2:0] ADDR_CLR    = 3'd2;
    localparam logic [2:0] ADDR_TOGGLE = 3'd3;
    localparam logic [2:0] ADDR_PRESC  = 3'd4;
    localparam logic [2:0] ADDR_DUTY   = 3'd5;

    localparam int PRESC_W = 16;

endpackage

// File: rtl/esn_led_pwm_gen.sv
// Global brightness gate: free-running prescaler feeding a DUTY_W-bit PWM
// counter, compared against DUTY to produce a registered pwm_on.
// DUTY all-ones forces the gate permanently on; DUTY=0 keeps it off.
module esn_led_pwm_gen
    import esn_led_pkg::*;
#(
    parameter int DUTY_W = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [PRESC_W-1:0] prescale,
    input  logic [DUTY_W-1:0]  duty,
    output logic               pwm_on
);

    logic [PRESC_W-1:0] cnt;
    logic [DUTY_W-1:0]  pwm_cnt;
    logic               tick;

    // Exact-match tick; if PRESCALE drops below cnt, cnt runs on and wraps.
    assign tick = (cnt == prescale);

    // Prescaler and PWM phase counter; writes never restart them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            pwm_cnt <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick)
                pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // Registered compare; reset value matches the all-ones DUTY reset state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            pwm_on <= 1'b1;
        else
            pwm_on <= (&duty) ? 1'b1 : (pwm_cnt < duty);
    end

endmodule

// File: rtl/esn_led_pio_pwm.sv
// Avalon-MM zero-wait-state LED output PIO with atomic SET/CLR/TOGGLE
// aliases. Define ESN_LED_PIO_PWM_EN to add the PRESCALE/DUTY registers and
// a global PWM brightness gate; without it the gate is tied on.
module esn_led_pio_pwm
    import esn_led_pkg::*;
#(
    parameter int                 WIDTH       = 8,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0,
    parameter int                 DUTY_W      = 8,
    parameter logic [PRESC_W-1:0] PRESC_RST   = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] wd;
    logic             wr_en;
    logic             pwm_on;

    assign wr_en = chipselect && !write_n;
    assign wd    = writedata[WIDTH-1:0];

    // DATA register with read-modify-write aliases resolved in one edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data <= RESET_VALUE;
        end else if (wr_en) begin
            case (address)
                ADDR_DATA:   data <= wd;
                ADDR_SET:    data <= data | wd;
                ADDR_CLR:    data <= data & ~wd;
                ADDR_TOGGLE: data <= data ^ wd;
                default:     ;
            endcase
        end
    end

`ifdef ESN_LED_PIO_PWM_EN
    logic [PRESC_W-1:0] prescale;
    logic [DUTY_W-1:0]  duty;

    // Brightness configuration registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescale <= PRESC_RST;
            duty     <= '1;
        end else if (wr_en) begin
            if (address == ADDR_PRESC) prescale <= writedata[PRESC_W-1:0];
            if (address == ADDR_DUTY)  duty     <= writedata[DUTY_W-1:0];
        end
    end

    esn_led_pwm_gen #(
        .DUTY_W (DUTY_W)
    ) u_pwm_gen (
        .clk      (clk),
        .reset_n  (reset_n),
        .prescale (prescale),
        .duty     (duty),
        .pwm_on   (pwm_on)
    );

    // Combinational read mux; aliases and reserved words read as zero.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:  readdata = 32'(data);
            ADDR_PRESC: readdata = 32'(prescale);
            ADDR_DUTY:  readdata = 32'(duty);
            default:    ;
        endcase
    end
`else
    // Configuration inputs that only matter to the brightness gate.
    logic [PRESC_W+DUTY_W-1:0] unused_cfg;
    assign unused_cfg = {PRESC_RST, {DUTY_W{1'b0}}};
    assign pwm_on     = 1'b1;

    // Combinational read mux; only DATA is readable in this build.
    always_comb begin
        readdata = '0;
        if (address == ADDR_DATA)
            readdata = 32'(data);
    end
`endif

    // Upper write-data bits are ignored for narrow ports.
    logic unused_wd;
    assign unused_wd = ^writedata;

    // LED drive flop: one edge behind DATA, gated by the brightness PWM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            out_port <= '0;
        else
            out_port <= data & {WIDTH{pwm_on}};
    end

endmodule
